posit_round_encode: RTL and testbench

POSIT_ROUND_ENCODE -- requirements
Module: posit_round_encode

---
 rtl/posit_pkg.sv | 30 +++
 rtl/posit_regime_shift.sv | 38 +++
 rtl/posit_round_encode.sv | 124 ++++++++++++
 tb/tb_posit_round_encode.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared posit definitions: FSM states, default geometry and special bit patterns.
package posit_pkg;

  localparam int unsigned POSIT_N  = 32;
  localparam int unsigned POSIT_ES = 3;
  localparam int unsigned POSIT_FW = 64;
  localparam int unsigned PAT_W    = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ROUND,
    S_PACK,
    S_DONE
  } state_t;

  // Patterns are returned right-aligned in PAT_W bits; callers truncate to N.
  function automatic logic [PAT_W-1:0] maxpos_pat(input int unsigned n);
    return (PAT_W'(1) << (n - 1)) - PAT_W'(1);
  endfunction

  function automatic logic [PAT_W-1:0] minpos_pat(input int unsigned n);
    return PAT_W'(n != 0);
  endfunction

  function automatic logic [PAT_W-1:0] nar_pat(input int unsigned n);
    return PAT_W'(1) << (n - 1);
  endfunction

endpackage

// File: rtl/posit_regime_shift.sv
// Builds the N-1 bit {regime, exp, frac} posit body and the guard/sticky bits.
module posit_regime_shift
  import posit_pkg::*;
#(
  parameter int unsigned N  = POSIT_N,
  parameter int unsigned ES = POSIT_ES,
  parameter int unsigned FW = POSIT_FW,
  parameter int unsigned KW = $clog2(N) + 2
) (
  input  logic signed [KW-1:0] k,
  input  logic [ES-1:0]        exp_bits,
  input  logic [FW-1:0]        frac,
  output logic [N-2:0]         body,
  output logic                 guard,
  output logic                 sticky
);

  localparam int unsigned PAD = 2 * N;
  localparam int unsigned WV  = 2 + ES + FW + PAD;

  logic [WV-1:0] seed;
  logic [WV-1:0] fill;
  logic [WV-1:0] stream;
  logic [KW-1:0] sh;

  // Seed is "10" (k>=0) or "01" (k<0) ahead of the tail; shifting right by k
  // (ones fill) or by -k-1 (zero fill) yields the full regime run.
  always_comb begin
    seed   = {~k[KW-1], k[KW-1], exp_bits, frac, {PAD{1'b0}}};
    sh     = k[KW-1] ? ~k : k;
    fill   = k[KW-1] ? '0 : ~({WV{1'b1}} >> sh);
    stream = (seed >> sh) | fill;
    body   = stream[WV-1 -: N-1];
    guard  = stream[WV-N];
    sticky = |stream[WV-N-1:0];
  end

endmodule

// File: rtl/posit_round_encode.sv
// Multi-cycle posit encoder: regime build, round-to-nearest-even, saturate, sign.
module posit_round_encode
  import posit_pkg::*;
#(
  parameter int unsigned N  = POSIT_N,
  parameter int unsigned ES = POSIT_ES,
  parameter int unsigned FW = POSIT_FW,
  parameter int unsigned KW = $clog2(N) + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sign_in,
  input  logic signed [KW-1:0] k_in,
  input  logic [ES-1:0]        exp_in,
  input  logic [FW-1:0]        frac_in,
  input  logic                 zero_in,
  input  logic                 nar_in,
  output logic [N-1:0]         posit_out,
  output logic                 done,
  output logic                 busy,
  output logic                 inexact,
  output logic                 saturated
);

  localparam logic signed [KW-1:0] K_HI   = KW'(int'(N) - 2);
  localparam logic signed [KW-1:0] K_LO   = KW'(1 - int'(N));
  localparam logic [N-1:0]         MAXPOS = N'(maxpos_pat(N));
  localparam logic [N-1:0]         MINPOS = N'(minpos_pat(N));
  localparam logic [N-1:0]         NAR    = N'(nar_pat(N));

  state_t st, st_next;

  logic                 sign_r, zero_r, nar_r;
  logic signed [KW-1:0] k_r;
  logic [ES-1:0]        exp_r;
  logic [FW-1:0]        frac_r;
  logic [N-2:0]         body_w, body_r;
  logic                 guard_w, sticky_w, guard_r, sticky_r;
  logic [N-1:0]         sum_r;
  logic [N-1:0]         mag, pack_val;
  logic                 pack_inx, pack_sat;

  posit_regime_shift #(.N(N), .ES(ES), .FW(FW), .KW(KW)) u_shift (
    .k        (k_r),
    .exp_bits (exp_r),
    .frac     (frac_r),
    .body     (body_w),
    .guard    (guard_w),
    .sticky   (sticky_w)
  );

  always_comb begin
    st_next = st;
    unique case (st)
      S_IDLE:  if (start) st_next = S_ALIGN;
      S_ALIGN: st_next = S_ROUND;
      S_ROUND: st_next = S_PACK;
      S_PACK:  st_next = S_DONE;
      S_DONE:  st_next = S_IDLE;
      default: st_next = S_IDLE;
    endcase
  end

  // Saturation by regime range takes priority over the rounded body.
  always_comb begin
    mag      = '0;
    pack_val = '0;
    pack_inx = 1'b0;
    pack_sat = 1'b0;
    if (nar_r) begin
      pack_val = NAR;
    end else if (!zero_r) begin
      pack_inx = guard_r | sticky_r;
      if (k_r >= K_HI || sum_r[N-1]) begin
        mag      = MAXPOS;
        pack_sat = 1'b1;
      end else if (k_r <= K_LO || sum_r[N-2:0] == '0) begin
        mag      = MINPOS;
        pack_sat = 1'b1;
      end else begin
        mag = sum_r;
      end
      pack_val = sign_r ? -mag : mag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_IDLE;
      posit_out <= '0;
      inexact   <= 1'b0;
      saturated <= 1'b0;
    end else begin
      st <= st_next;
      unique case (st)
        S_IDLE: if (start) begin
          sign_r <= sign_in;
          k_r    <= k_in;
          exp_r  <= exp_in;
          frac_r <= frac_in;
          zero_r <= zero_in;
          nar_r  <= nar_in;
        end
        S_ALIGN: begin
          body_r   <= body_w;
          guard_r  <= guard_w;
          sticky_r <= sticky_w;
        end
        S_ROUND: sum_r <= {1'b0, body_r} + N'(guard_r & (body_r[0] | sticky_r));
        S_PACK: begin
          posit_out <= pack_val;
          inexact   <= pack_inx;
          saturated <= pack_sat;
        end
        default: ;
      endcase
    end
  end

  assign done = (st == S_DONE);
  assign busy = (st != S_IDLE);

endmodule

// File: tb/tb_posit_round_encode.sv
// Directed and randomized checks of posit_round_encode against a bit-stream model.
module tb_posit_round_encode;

  localparam int N  = 32;
  localparam int ES = 3;
  localparam int FW = 64;
  localparam int KW = 7;

  logic                 clk = 1'b0;
  logic                 rst, start, sign_in, zero_in, nar_in;
  logic signed [KW-1:0] k_in;
  logic [ES-1:0]        exp_in;
  logic [FW-1:0]        frac_in;
  logic [N-1:0]         posit_out;
  logic                 done, busy, inexact, saturated;

  int unsigned passed = 0;
  int unsigned total  = 0;

  posit_round_encode #(.N(N), .ES(ES), .FW(FW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sign_in   (sign_in),
    .k_in      (k_in),
    .exp_in    (exp_in),
    .frac_in   (frac_in),
    .zero_in   (zero_in),
    .nar_in    (nar_in),
    .posit_out (posit_out),
    .done      (done),
    .busy      (busy),
    .inexact   (inexact),
    .saturated (saturated)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: lay out the posit bit stream literally, cut it, round, clamp.
  function automatic void model(input bit s, input int k, input bit [2:0] e,
                                input bit [63:0] f, input bit z, input bit n,
                                output bit [31:0] p, output bit inx, output bit sat);
    bit     q[$];
    longint body, mag;
    bit     g, stk;
    p = '0; inx = 1'b0; sat = 1'b0;
    if (n) begin p = 32'h8000_0000; return; end
    if (z) return;
    if (k >= 0) begin
      for (int i = 0; i <= k; i++) q.push_back(1'b1);
      q.push_back(1'b0);
    end else begin
      for (int i = 0; i < -k; i++) q.push_back(1'b0);
      q.push_back(1'b1);
    end
    for (int i = 2; i >= 0; i--) q.push_back(e[i]);
    for (int i = 63; i >= 0; i--) q.push_back(f[i]);
    body = 0;
    for (int i = 0; i < 31; i++) body = body * 2 + longint'(q[i]);
    g = q[31];
    stk = 1'b0;
    for (int i = 32; i < q.size(); i++) stk |= q[i];
    inx = g | stk;
    if (k >= 30) begin
      mag = (longint'(1) << 31) - 1; sat = 1'b1;
    end else if (k <= -31) begin
      mag = 1; sat = 1'b1;
    end else begin
      mag = body + ((g && ((body % 2) == 1 || stk)) ? 1 : 0);
      if (mag >= (longint'(1) << 31)) begin
        mag = (longint'(1) << 31) - 1; sat = 1'b1;
      end else if (mag == 0) begin
        mag = 1; sat = 1'b1;
      end
    end
    p = s ? 32'(-mag) : 32'(mag);
  endfunction

  task automatic run_op(input string tag, input bit s, input int k, input bit [2:0] e,
                        input bit [63:0] f, input bit z, input bit n,
                        input bit [31:0] ep, input bit ei, input bit es);
    int lat = 0;
    sign_in = s; k_in = KW'(k); exp_in = e; frac_in = f; zero_in = z; nar_in = n;
    start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
      if (done) begin lat = i; break; end
    end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_posit"}, 64'(posit_out), 64'(ep));
    check({tag, "_inexact"}, 64'(inexact), 64'(ei));
    check({tag, "_sat"}, 64'(saturated), 64'(es));
    @(posedge clk); #1;
    check({tag, "_done_fall"}, 64'(done), 64'd0);
  endtask

  initial begin
    bit [31:0] ep;
    bit        ei, es, s, z, n;
    int        k, pulses;
    bit [2:0]  e;
    bit [63:0] f;

    rst = 1'b1; start = 1'b1; sign_in = 1'b0; k_in = '0; exp_in = '0;
    frac_in = '0; zero_in = 1'b0; nar_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_posit", 64'(posit_out), 64'd0);
    check("rst_flags", 64'({inexact, saturated}), 64'd0);

    run_op("one",      0,   0, 3'd0, 64'h0,                  0, 0, 32'h4000_0000, 0, 0);
    run_op("one_5",    0,   0, 3'd0, 64'h8000_0000_0000_0000, 0, 0, 32'h4200_0000, 0, 0);
    run_op("neg_1_5",  1,   0, 3'd0, 64'h8000_0000_0000_0000, 0, 0, 32'hBE00_0000, 0, 0);
    run_op("tie_even", 0,   0, 3'd0, 64'h0000_0020_0000_0000, 0, 0, 32'h4000_0000, 1, 0);
    run_op("tie_odd",  0,   0, 3'd0, 64'h0000_0060_0000_0000, 0, 0, 32'h4000_0002, 1, 0);
    run_op("k_big",    0,  40, 3'd0, 64'h0,                  0, 0, 32'h7FFF_FFFF, 1, 1);
    run_op("k_small",  0, -40, 3'd0, 64'h0,                  0, 0, 32'h0000_0001, 1, 1);
    run_op("nar",      0,   0, 3'd0, 64'h0,                  1, 1, 32'h8000_0000, 0, 0);
    run_op("zero",     1,   5, 3'd5, 64'h1234,               1, 0, 32'h0000_0000, 0, 0);
    run_op("k_29_rnd", 0,  29, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 32'h7FFF_FFFF, 1, 0);
    run_op("k_m30",    0, -30, 3'd0, 64'h0,                  0, 0, 32'h0000_0001, 0, 0);
    run_op("k_m31",    1, -31, 3'd0, 64'h0,                  0, 0, 32'hFFFF_FFFF, 1, 1);

    for (int t = 0; t < 60; t++) begin
      s = 1'($urandom);
      k = int'($urandom_range(0, 80)) - 40;
      if (t % 3 == 0) k = int'($urandom_range(0, 12)) - 6;
      e = 3'($urandom);
      f = {$urandom, $urandom};
      if (t % 5 == 1) f[35:0] = '0;
      z = ($urandom_range(0, 15) == 0);
      n = ($urandom_range(0, 15) == 0);
      model(s, k, e, f, z, n, ep, ei, es);
      run_op("rand", s, k, e, f, z, n, ep, ei, es);
    end

    // Abort in ROUND after a saturated result is already on the outputs.
    run_op("pre_abort", 0, 40, 3'd0, 64'h0, 0, 0, 32'h7FFF_FFFF, 1, 1);
    k_in = '0; frac_in = '0; zero_in = 1'b0; nar_in = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_posit", 64'(posit_out), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_flags", 64'({done, inexact, saturated}), 64'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);

    // start held through the whole operation yields a single completion.
    sign_in = 1'b1; k_in = '0; exp_in = '0; frac_in = 64'h8000_0000_0000_0000;
    start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    start = 1'b0;
    check("held_posit", 64'(posit_out), 64'hBE00_0000);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("held_one_done", 64'(pulses), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
